// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle for fifo_burst_reader: control, FIFO read port and downstream stream.
// The slave modport is the reader engine; the master modport is its environment.
interface fifo_burst_reader_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 9
);
  logic             i_Start;
  logic [LEN_W-1:0] i_Burst_Len;
  logic             o_Busy;
  logic             o_Done;
  logic             i_Fifo_Empty;
  logic             o_Fifo_Rd_En;
  logic [WIDTH-1:0] i_Fifo_Rd_Data;
  logic             o_Tx_DV;
  logic [WIDTH-1:0] o_Tx_Data;
  logic             i_Tx_Ready;

  modport slave (
    input  i_Start, i_Burst_Len, i_Fifo_Empty, i_Fifo_Rd_Data, i_Tx_Ready,
    output o_Busy, o_Done, o_Fifo_Rd_En, o_Tx_DV, o_Tx_Data
  );

  modport master (
    output i_Start, i_Burst_Len, i_Fifo_Empty, i_Fifo_Rd_Data, i_Tx_Ready,
    input  o_Busy, o_Done, o_Fifo_Rd_En, o_Tx_DV, o_Tx_Data
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst read engine: pops a programmed number of words from a 1-cycle-latency FIFO and
// streams them downstream through a 2-entry skid buffer at up to one word per clock.
module fifo_burst_reader #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 9
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  fifo_burst_reader_if.slave  io_Bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           r_State;
  logic [LEN_W-1:0] r_Req_Left;
  logic [LEN_W-1:0] r_Out_Left;
  logic             r_Busy;
  logic             r_Done;

  logic [WIDTH-1:0] r_Buf [2];
  logic             r_Head;
  logic [1:0]       r_Count;
  logic             r_Inflight;

  logic             w_Pop;
  logic             w_Rd_En;
  logic             w_Tail;
  logic [2:0]       w_Occ;

  assign w_Pop  = (r_Count != 2'd0) & io_Bus.i_Tx_Ready;
  // Occupancy the buffer will hold after this edge, counting the word still in flight.
  assign w_Occ  = {1'b0, r_Count} + {2'b00, r_Inflight} - {2'b00, w_Pop};
  assign w_Tail = r_Head ^ r_Count[0];

  assign w_Rd_En = (r_State == StRun) & ~io_Bus.i_Fifo_Empty &
                   (r_Req_Left != '0) & (w_Occ < 3'd2);

  assign io_Bus.o_Fifo_Rd_En = w_Rd_En;
  assign io_Bus.o_Tx_DV      = (r_Count != 2'd0);
  assign io_Bus.o_Tx_Data    = r_Buf[r_Head];
  assign io_Bus.o_Busy       = r_Busy;
  assign io_Bus.o_Done       = r_Done;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State    <= StIdle;
      r_Req_Left <= '0;
      r_Out_Left <= '0;
      r_Busy     <= 1'b0;
      r_Done     <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      unique case (r_State)
        StIdle: begin
          if (io_Bus.i_Start) begin
            if (io_Bus.i_Burst_Len != '0) begin
              r_Req_Left <= io_Bus.i_Burst_Len;
              r_Out_Left <= io_Bus.i_Burst_Len;
              r_Busy     <= 1'b1;
              r_State    <= StRun;
            end else begin
              r_Done  <= 1'b1;
              r_State <= StDone;
            end
          end
        end
        StRun: begin
          if (w_Rd_En) begin
            r_Req_Left <= r_Req_Left - LEN_W'(1);
            if (r_Req_Left == LEN_W'(1)) r_State <= StDrain;
          end
          if (w_Pop) r_Out_Left <= r_Out_Left - LEN_W'(1);
        end
        StDrain: begin
          // The final pop always lands here: the last word is read at least two cycles
          // after the last request leaves RUN.
          if (w_Pop) begin
            r_Out_Left <= r_Out_Left - LEN_W'(1);
            if (r_Out_Left == LEN_W'(1)) begin
              r_Busy  <= 1'b0;
              r_Done  <= 1'b1;
              r_State <= StDone;
            end
          end
        end
        StDone: begin
          r_State <= StIdle;
        end
        default: begin
          r_State <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Inflight <= 1'b0;
      r_Head     <= 1'b0;
      r_Count    <= 2'd0;
      r_Buf[0]   <= '0;
      r_Buf[1]   <= '0;
    end else begin
      r_Inflight <= w_Rd_En;
      if (r_Inflight) r_Buf[w_Tail] <= io_Bus.i_Fifo_Rd_Data;
      if (w_Pop) r_Head <= ~r_Head;
      unique case ({r_Inflight, w_Pop})
        2'b10:   r_Count <= r_Count + 2'd1;
        2'b01:   r_Count <= r_Count - 2'd1;
        default: r_Count <= r_Count;
      endcase
    end
  end

endmodule
